// File: rtl/machine_anode_scan_pkg.sv
// Shared constants and types for the four-digit anode scanner.
// The segment table is active-low, bit order {g,f,e,d,c,b,a}.
package machine_anode_scan_pkg;

    localparam int DIGIT_W = 2;
    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Packed so that HEX_SEG[n] is the pattern for nibble n (entry 15 written first)
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic {
        LD_IDLE    = 1'b0,
        LD_PENDING = 1'b1
    } ld_state_e;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  blank;
        logic [3:0]  dp;
    } disp_t;

    function automatic logic [3:0] anode_for(input logic [DIGIT_W-1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/machine_anode_scan_if.sv
// Load port of the scanner: a 16-bit hex value plus blank/dp masks under valid/ready.
interface machine_anode_scan_if;

    logic [15:0] load_data;
    logic [3:0]  load_blank;
    logic [3:0]  load_dp;
    logic        load_valid;
    logic        load_ready;

    modport master (
        output load_data,
        output load_blank,
        output load_dp,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  load_data,
        input  load_blank,
        input  load_dp,
        input  load_valid,
        output load_ready
    );

endinterface

// File: rtl/machine_hex_to_seg.sv
// Combinational nibble to active-low seven-segment pattern.
module machine_hex_to_seg
    import machine_anode_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/machine_anode_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-aligned value swap.
//
// state      | meaning
// LD_IDLE    | no value waiting; load port ready
// LD_PENDING | shadow holds a new value; swapped in at the next frame boundary
module machine_anode_scan
    import machine_anode_scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GHOST_CYCLES = 16
) (
    input  logic                 system1000,
    input  logic                 system1000_rst,
    machine_anode_scan_if.slave  load,
    output logic [3:0]           anode_n,
    output logic                 anode_valid,
    output logic [6:0]           seg_n,
    output logic                 dp_n,
    output logic                 frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYCLES);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    ld_state_e          state_q, state_d;
    disp_t              shadow_q, shadow_d;
    disp_t              disp_q, disp_d;

    logic [3:0] anode_q, anode_d;
    logic       valid_q, valid_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic       tick_q, tick_d;

    logic       slot_end;
    logic       frame_end;
    logic       accept;
    logic       ghost;
    logic [3:0] nibble;
    logic [6:0] seg_dec;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (digit_q == DIGIT_LAST);
    assign ghost     = (cnt_q < CNT_GHOST);

    // Gated by reset so nothing can be accepted while the block is being cleared
    assign load.load_ready = ~system1000_rst & (state_q == LD_IDLE);
    assign accept          = load.load_valid & load.load_ready;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        case (state_q)
            LD_IDLE: begin
                if (accept) begin
                    shadow_d = '{data: load.load_data, blank: load.load_blank, dp: load.load_dp};
                    state_d  = LD_PENDING;
                end
            end
            LD_PENDING: begin
                if (frame_end) begin
                    disp_d  = shadow_q;
                    state_d = LD_IDLE;
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = slot_end ? '0 : cnt_q + CNT_W'(1);
        digit_d = slot_end ? digit_q + DIGIT_W'(1) : digit_q;
    end

    assign nibble = disp_q.data[{digit_q, 2'b00} +: 4];

    machine_hex_to_seg u_hex_to_seg (
        .nibble_i (nibble),
        .seg_n_o  (seg_dec)
    );

    // All three display buses are decided together and registered on one edge
    always_comb begin
        anode_d = ANODE_OFF;
        valid_d = 1'b0;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        tick_d  = frame_end;
        if (!ghost) begin
            anode_d = anode_for(digit_q);
            valid_d = 1'b1;
            if (!disp_q.blank[digit_q]) begin
                seg_d = seg_dec;
                dp_d  = ~disp_q.dp[digit_q];
            end
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            cnt_q    <= '0;
            digit_q  <= '0;
            state_q  <= LD_IDLE;
            shadow_q <= '{data: 16'h0000, blank: 4'h0, dp: 4'h0};
            disp_q   <= '{data: 16'h0000, blank: 4'hF, dp: 4'h0};
            anode_q  <= ANODE_OFF;
            valid_q  <= 1'b0;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            state_q  <= state_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            anode_q  <= anode_d;
            valid_q  <= valid_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    assign anode_n     = anode_q;
    assign anode_valid = valid_q;
    assign seg_n       = seg_q;
    assign dp_n        = dp_q;
    assign frame_tick  = tick_q;

endmodule

// File: tb/tb_machine_anode_scan.sv
// Bench for machine_anode_scan: frame-position reference model, vector table and random loads.
module tb_machine_anode_scan;

    localparam int DIV   = 8;
    localparam int GHOST = 2;
    localparam int FRAME = DIV * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] anode_n;
    logic       anode_valid;
    logic [6:0] seg_n;
    logic       dp_n;
    logic       frame_tick;

    machine_anode_scan_if ld ();

    machine_anode_scan #(
        .REFRESH_DIV  (DIV),
        .GHOST_CYCLES (GHOST)
    ) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .load           (ld),
        .anode_n        (anode_n),
        .anode_valid    (anode_valid),
        .seg_n          (seg_n),
        .dp_n           (dp_n),
        .frame_tick     (frame_tick)
    );

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      blank;
        logic [3:0]      dp;
        int              phase;
        int              lat;
        logic [3:0][6:0] seg;
        logic [3:0]      dpn;
    } vec_t;

    vec_t       tbl [4];
    logic [6:0] hex_ref [16];

    int tests = 0;
    int fails = 0;

    // Model state: p = clocks since reset; frames are FRAME clocks long
    int          p;
    logic        pend_m;
    int          pend_frame;
    logic [15:0] pend_data, cur_data, prev_data;
    logic [3:0]  pend_blank, cur_blank, prev_blank;
    logic [3:0]  pend_dp, cur_dp, prev_dp;
    logic        ready_seen;
    bit          cap_en;
    int          cap_idx;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at pos %0d: got %h expected %h", name, p, got, exp);
        end
    endtask

    task automatic model_reset();
        p = 0;
        pend_m = 1'b0;
        pend_frame = 0;
        cur_data = 16'h0000;  prev_data = 16'h0000;
        cur_blank = 4'hF;     prev_blank = 4'hF;
        cur_dp = 4'h0;        prev_dp = 4'h0;
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic [3:0] b,
                        input logic [3:0] dpi, input logic r);
        logic       rdy_exp, acc, dp_e, vl_e, tk_e;
        logic [3:0] an_e;
        logic [6:0] sg_e;
        int         s, dg;
        ld.load_valid = v;
        ld.load_data  = d;
        ld.load_blank = b;
        ld.load_dp    = dpi;
        rst           = r;
        @(negedge clk);
        rdy_exp = !r && !pend_m;
        an_e = 4'hF; sg_e = 7'h7F; dp_e = 1'b1; vl_e = 1'b0;
        tk_e = (p > 0) && (p % FRAME == 0);
        dg = 0;
        if (p > 0) begin
            s  = p - 1;
            dg = (s / DIV) % 4;
            if (s % DIV >= GHOST) begin
                an_e = 4'hF;
                an_e[dg] = 1'b0;
                vl_e = 1'b1;
                if (!prev_blank[dg]) begin
                    sg_e = hex_ref[prev_data[dg*4 +: 4]];
                    dp_e = !prev_dp[dg];
                end
            end
        end
        chk("anode_n",     16'(anode_n),        16'(an_e));
        chk("anode_valid", 16'(anode_valid),    16'(vl_e));
        chk("seg_n",       16'(seg_n),          16'(sg_e));
        chk("dp_n",        16'(dp_n),           16'(dp_e));
        chk("frame_tick",  16'(frame_tick),     16'(tk_e));
        chk("load_ready",  16'(ld.load_ready),  16'(rdy_exp));
        ready_seen = ld.load_ready;
        if (cap_en && vl_e) begin
            chk("tbl_seg", 16'(seg_n), 16'(tbl[cap_idx].seg[dg]));
            chk("tbl_dp",  16'(dp_n),  16'(tbl[cap_idx].dpn[dg]));
        end
        acc = v && rdy_exp;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            prev_data = cur_data; prev_blank = cur_blank; prev_dp = cur_dp;
            if (pend_m && (p + 1 == pend_frame * FRAME)) begin
                cur_data = pend_data; cur_blank = pend_blank; cur_dp = pend_dp;
                pend_m = 1'b0;
            end
            if (acc) begin
                pend_m = 1'b1;
                pend_data = d; pend_blank = b; pend_dp = dpi;
                pend_frame = (p + 1) / FRAME + 1;
            end
            p = p + 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic load_vec(input int idx);
        int n;
        n = 0;
        while ((pend_m || (tbl[idx].phase >= 0 && p % FRAME != tbl[idx].phase)) && n < 200) begin
            idle(1);
            n++;
        end
        step(1'b1, tbl[idx].data, tbl[idx].blank, tbl[idx].dp, 1'b0);
        n = 0;
        idle(1);
        while (!ready_seen && n < 100) begin
            n++;
            idle(1);
        end
        if (tbl[idx].lat >= 0) chk("swap_latency", 16'(n), 16'(tbl[idx].lat));
        else chk("swap_bounded", 16'(n < 100), 16'(1));
        cap_en = 1'b1;
        cap_idx = idx;
        idle(FRAME);
        cap_en = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  rb, rp;
        int          n;

        hex_ref[0]  = 7'b1000000; hex_ref[1]  = 7'b1111001; hex_ref[2]  = 7'b0100100;
        hex_ref[3]  = 7'b0110000; hex_ref[4]  = 7'b0011001; hex_ref[5]  = 7'b0010010;
        hex_ref[6]  = 7'b0000010; hex_ref[7]  = 7'b1111000; hex_ref[8]  = 7'b0000000;
        hex_ref[9]  = 7'b0010000; hex_ref[10] = 7'b0001000; hex_ref[11] = 7'b0000011;
        hex_ref[12] = 7'b1000110; hex_ref[13] = 7'b0100001; hex_ref[14] = 7'b0000110;
        hex_ref[15] = 7'b0001110;

        tbl[0] = '{data: 16'h1234, blank: 4'b0000, dp: 4'b0100, phase: 3, lat: -1,
                   seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, dpn: 4'b1011};
        tbl[1] = '{data: 16'hFFFF, blank: 4'b0000, dp: 4'b0000, phase: 10, lat: 21,
                   seg: {7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110}, dpn: 4'b1111};
        tbl[2] = '{data: 16'hABCD, blank: 4'b0000, dp: 4'b1001, phase: 31, lat: 32,
                   seg: {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, dpn: 4'b0110};
        tbl[3] = '{data: 16'h8888, blank: 4'b1010, dp: 4'b0000, phase: 5, lat: -1,
                   seg: {7'b1111111, 7'b0000000, 7'b1111111, 7'b0000000}, dpn: 4'b1111};

        cap_en = 1'b0;
        cap_idx = 0;
        ready_seen = 1'b0;
        rst = 1'b1;
        ld.load_valid = 1'b0;
        ld.load_data = 16'h0000;
        ld.load_blank = 4'h0;
        ld.load_dp = 4'h0;
        model_reset();
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 4'h0, 4'h0, 1'b1);

        for (int i = 0; i < 4; i++) load_vec(i);

        // Reset in the middle of a lit slot
        n = 0;
        while (p % DIV != 4 && n < 20) begin idle(1); n++; end
        step(1'b0, 16'h0000, 4'h0, 4'h0, 1'b1);
        idle(5);

        // A pending value is lost across reset
        step(1'b1, 16'h5555, 4'h0, 4'h0, 1'b0);
        idle(3);
        step(1'b0, 16'h0000, 4'h0, 4'h0, 1'b1);
        idle(2 * FRAME + 4);

        for (int i = 0; i < 2500; i++) begin
            rd = 16'($urandom);
            rb = 4'($urandom);
            rp = 4'($urandom);
            step($urandom_range(0, 3) == 0, rd, rb, rp, $urandom_range(0, 399) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
